// File: rtl/fma_pkg.sv
// Shared types and arithmetic helpers for the FP16 x INT8 / 2xFP4 lane array.
// Lane arithmetic works in an exact fixed-point frame. That frame is wide
// enough to hold any sum of an FP16 accumulator and one product. Only the
// final normalization truncates, so every add rounds toward zero.
package fma_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;
    localparam int FP4_BIAS   = 1;
    localparam int PROD_EXP_W = 6;
    localparam int PROD_MAN_W = 19;

    // Fixed-point LSB weight is 2^-FX_FRAC. That LSB covers the smallest FP4 product.
    localparam int FX_FRAC = FP16_BIAS + FP16_MAN_W;
    localparam int FX_W    = 52;

    typedef enum logic {
        MODE_INT8  = 1'b0,
        MODE_FP4X2 = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Product value = man * 2^(exp - FX_FRAC - FP4_BIAS)
    typedef struct packed {
        logic                  sign;
        logic [PROD_EXP_W-1:0] exp;
        logic [PROD_MAN_W-1:0] man;
    } prod_t;

    // E2M1 magnitude in units of 0.5 (codes 0..7 -> 0,0.5,1,1.5,2,3,4,6)
    function automatic logic [3:0] fp4_mag(input logic [2:0] code);
        logic [3:0] m;
        case (code)
            3'd0:    m = 4'd0;
            3'd1:    m = 4'd1;
            3'd2:    m = 4'd2;
            3'd3:    m = 4'd3;
            3'd4:    m = 4'd4;
            3'd5:    m = 4'd6;
            3'd6:    m = 4'd8;
            default: m = 4'd12;
        endcase
        return m;
    endfunction

    // INT8 weights carry no half-unit scale. The exponent is raised by FP4_BIAS to share the frame.
    function automatic prod_t mul_int8(input logic [15:0] a, input logic [7:0] w);
        prod_t      p;
        logic [7:0] mag;
        logic [10:0] sig;
        p   = '0;
        mag = w[7] ? (~w + 8'd1) : w;
        sig = {1'b1, a[9:0]};
        if (a[14:10] != '0) begin
            p.sign = a[15] ^ w[7];
            p.exp  = {1'b0, a[14:10]} + 6'(FP4_BIAS);
            p.man  = 19'(sig) * 19'(mag);
        end
        return p;
    endfunction

    function automatic prod_t mul_fp4(input logic [15:0] a, input logic [3:0] code);
        prod_t       p;
        logic [10:0] sig;
        p   = '0;
        sig = {1'b1, a[9:0]};
        if (a[14:10] != '0) begin
            p.sign = a[15] ^ code[3];
            p.exp  = {1'b0, a[14:10]};
            p.man  = 19'(sig) * 19'(fp4_mag(code[2:0]));
        end
        return p;
    endfunction

    function automatic logic signed [FX_W-1:0] acc_to_fx(input logic [15:0] a);
        logic [FX_W-1:0] m;
        m = '0;
        if (a[14:10] != '0)
            m = FX_W'({1'b1, a[9:0]}) << a[14:10];
        return a[15] ? -$signed(m) : $signed(m);
    endfunction

    function automatic logic signed [FX_W-1:0] prod_to_fx(input prod_t p);
        logic [FX_W-1:0] m;
        m = '0;
        if (p.exp >= 6'(FP4_BIAS))
            m = FX_W'(p.man) << (p.exp - 6'(FP4_BIAS));
        return p.sign ? -$signed(m) : $signed(m);
    endfunction

    // Truncating normalizer. Results below the normal range flush to +0. Overflow saturates to inf.
    function automatic logic [15:0] fx_norm(input logic signed [FX_W-1:0] s);
        logic [FX_W-1:0] mag;
        logic [15:0]     r;
        int              pos;
        int              e;
        mag = s[FX_W-1] ? $unsigned(-s) : $unsigned(s);
        pos = 0;
        for (int i = 0; i < FX_W; i++)
            if (mag[i]) pos = i;
        e = pos - FX_FRAC + FP16_BIAS;
        r = '0;
        if (mag == '0 || e <= 0)
            r = '0;
        else if (e >= 31)
            r = {s[FX_W-1], 5'h1F, 10'h000};
        else
            r = {s[FX_W-1], e[FP16_EXP_W-1:0], FP16_MAN_W'(mag >> (pos - FP16_MAN_W))};
        return r;
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] a, input prod_t p);
        return fx_norm(acc_to_fx(a) + prod_to_fx(p));
    endfunction

endpackage

// File: rtl/fma_lane.sv
// One FMA lane. The multiplier result is registered into stage 1. Stage 2
// then adds it into the two FP16 accumulators.
module fma_lane
    import fma_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clr,
    input  mode_e       mode,
    input  logic [15:0] act,
    input  logic [7:0]  wgt,
    output logic [15:0] acc1,
    output logic [15:0] acc2
);

    prod_t       prod1;
    prod_t       prod2;
    prod_t       p1_q;
    prod_t       p2_q;
    logic        vld_q;
    logic [15:0] sum1;
    logic [15:0] sum2;

    // Dual-mode multiply. In INT8 mode the acc1 path sees a zero product.
    always_comb begin
        prod1 = '0;
        prod2 = '0;
        if (mode == MODE_FP4X2) begin
            prod1 = mul_fp4(act, wgt[7:4]);
            prod2 = mul_fp4(act, wgt[3:0]);
        end else begin
            prod2 = mul_int8(act, wgt);
        end
    end

    // Stage 1: capture the products of an accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_q  <= '0;
            p2_q  <= '0;
            vld_q <= 1'b0;
        end else if (clr) begin
            p1_q  <= '0;
            p2_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= en;
            if (en) begin
                p1_q <= prod1;
                p2_q <= prod2;
            end
        end
    end

    // Adder and normalizer cores, one per accumulator.
    always_comb begin
        sum1 = fp_add(acc1, p1_q);
        sum2 = fp_add(acc2, p2_q);
    end

    // Stage 2: update the accumulators when stage 1 holds a product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc1 <= '0;
            acc2 <= '0;
        end else if (clr) begin
            acc1 <= '0;
            acc2 <= '0;
        end else if (vld_q) begin
            acc1 <= sum1;
            acc2 <= sum2;
        end
    end

endmodule

// File: rtl/fma_lane_array_acc.sv
// Multi-lane self-accumulating FMA. There is one shared sequencer and beat counter.
// The lanes are packed 16 bits (activations/results) or 8 bits (weights) each.
//
// state | meaning
// IDLE  | waiting for the first beat; cfg_mode/cfg_len sampled on it
// ACCUM | accepting beats until the counter reaches the latched length
// DRAIN | one cycle for stage 2 to absorb the last product
// HOLD  | result presented; cleared on out_valid/out_ready handshake
module fma_lane_array_acc
    import fma_pkg::*;
#(
    parameter int LANES = 4,
    parameter int K_MAX = 256,
    parameter int CNT_W = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_mode,
    input  logic [CNT_W-1:0]      cfg_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   act,
    input  logic [8*LANES-1:0]    wgt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_acc1,
    output logic [16*LANES-1:0]   out_acc2,
    output logic                  busy
);

    state_e           state_q;
    state_e           state_d;
    mode_e            mode_q;
    mode_e            lane_mode;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_clamped;
    logic             beat;
    logic             clr;

    assign len_clamped = (cfg_len > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : cfg_len;

    // Next-state and handshake outputs. in_ready is held low while reset is asserted.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = reset_n && (cfg_len != '0);
                if (in_valid && cfg_len != '0)
                    state_d = (len_clamped == CNT_W'(1)) ? DRAIN : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (cnt_q + CNT_W'(1)) == len_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign beat      = in_valid && in_ready;
    assign clr       = (state_q == HOLD) && out_ready;
    assign busy      = (state_q != IDLE);
    assign lane_mode = (state_q == IDLE) ? mode_e'(cfg_mode) : mode_q;

    // Configuration latch and beat counter. Config is only sampled on the first beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= MODE_INT8;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && beat) begin
                mode_q <= mode_e'(cfg_mode);
                len_q  <= len_clamped;
                cnt_q  <= CNT_W'(1);
            end else if (state_q == ACCUM && beat) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end else if (clr) begin
                cnt_q  <= '0;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fma_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (beat),
            .clr     (clr),
            .mode    (lane_mode),
            .act     (act[16*i +: 16]),
            .wgt     (wgt[8*i +: 8]),
            .acc1    (out_acc1[16*i +: 16]),
            .acc2    (out_acc2[16*i +: 16])
        );
    end

endmodule

// File: tb/tb_fma_lane_array_acc.sv
// Bench for fma_lane_array_acc: vector table plus hand-written corner sequences,
// with a result scoreboard popped by an output monitor.
module tb_fma_lane_array_acc;

    localparam int LANES = 4;
    localparam int K_MAX = 256;
    localparam int CNT_W = 9;

    logic                 clk;
    logic                 reset_n;
    logic                 cfg_mode;
    logic [CNT_W-1:0]     cfg_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [16*LANES-1:0]  act;
    logic [8*LANES-1:0]   wgt;
    logic                 out_valid;
    logic                 out_ready;
    logic [16*LANES-1:0]  out_acc1;
    logic [16*LANES-1:0]  out_acc2;
    logic                 busy;

    fma_lane_array_acc #(.LANES(LANES), .K_MAX(K_MAX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_mode  (cfg_mode),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act       (act),
        .wgt       (wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc1  (out_acc1),
        .out_acc2  (out_acc2),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [8:0]  len;
        logic [63:0] act;
        logic [31:0] wgt;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    typedef struct packed {
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endfunction

    function automatic void bound_expired(input string nm);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired", nm);
    endfunction

    function automatic vec_t mk(input logic m, input logic [8:0] l, input logic [63:0] a,
                                input logic [31:0] w, input logic [63:0] e1, input logic [63:0] e2);
        vec_t v;
        v.mode = m; v.len = l; v.act = a; v.wgt = w; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    // Output monitor: compare on each out_valid/out_ready handshake.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=out_valid want=no pending result");
                end else begin
                    e = sb.pop_front();
                    check("out_acc1", out_acc1, e.e1);
                    check("out_acc2", out_acc2, e.e2);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic m, input logic [8:0] l, input logic [63:0] a, input logic [31:0] w);
        int g;
        @(negedge clk);
        cfg_mode = m; cfg_len = l; act = a; wgt = w; in_valid = 1'b1;
        #1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk); #1; g++;
        end
        if (!in_ready) bound_expired("in_ready");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic reduce(input logic m, input logic [8:0] l, input logic m2, input logic [8:0] l2,
                          input int nb, input logic [63:0] a, input logic [31:0] w,
                          input logic [63:0] e1, input logic [63:0] e2, input int gap);
        sb.push_back({e1, e2});
        for (int b = 0; b < nb; b++) begin
            send_beat((b == 0) ? m : m2, (b == 0) ? l : l2, a, w);
            if (b != nb - 1) repeat (gap) @(posedge clk);
        end
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);
        check("drain_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (busy) bound_expired("wait_idle");
        check("cleared_acc1", out_acc1, 64'd0);
        check("cleared_acc2", out_acc2, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; cfg_mode = 1'b0; cfg_len = 9'd1; in_valid = 1'b0;
        act = '0; wgt = '0; out_ready = 1'b1;

        vecs.push_back(mk(1'b0, 9'd4, {4{16'h3C00}}, {4{8'h02}}, 64'd0, {4{16'h4800}}));
        vecs.push_back(mk(1'b0, 9'd3, {4{16'h3C00}}, {4{8'hFF}}, 64'd0, {4{16'hC200}}));
        vecs.push_back(mk(1'b0, 9'd1, {16'h4800, 16'h4400, 16'h4000, 16'h3C00}, {4{8'h01}},
                          64'd0, {16'h4800, 16'h4400, 16'h4000, 16'h3C00}));
        vecs.push_back(mk(1'b1, 9'd2, {4{16'h4000}}, {4{8'h42}}, {4{16'h4800}}, {4{16'h4400}}));
        vecs.push_back(mk(1'b0, 9'd1, {16'hC000, 16'h0001, 16'h3C01, 16'h3C01},
                          {8'h80, 8'h7F, 8'hFD, 8'h03},
                          64'd0, {16'h5C00, 16'h0000, 16'hC201, 16'h4201}));
        vecs.push_back(mk(1'b1, 9'd1, {16'h3C00, 16'h4000, 16'h3C00, 16'h4000},
                          {8'h35, 8'h80, 8'h7F, 8'h19},
                          {16'h3E00, 16'h0000, 16'h4600, 16'h3C00},
                          {16'h4200, 16'h0000, 16'hC600, 16'hBC00}));
        vecs.push_back(mk(1'b1, 9'd3, {4{16'h3C00}}, {4{8'h53}}, {4{16'h4880}}, {4{16'h4480}}));

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_acc1", out_acc1, 64'd0);
        check("rst_acc2", out_acc2, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            reduce(vecs[i].mode, vecs[i].len, vecs[i].mode, vecs[i].len, int'(vecs[i].len),
                   vecs[i].act, vecs[i].wgt, vecs[i].e1, vecs[i].e2, 0);
            wait_idle();
        end

        // Input gaps: only accepted beats count.
        reduce(1'b0, 9'd4, 1'b0, 9'd4, 4, {4{16'h3C00}}, {4{8'h02}}, 64'd0, {4{16'h4800}}, 1);
        wait_idle();

        // cfg_len == 0 in IDLE: nothing accepted.
        @(negedge clk);
        cfg_len = 9'd0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("len0_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            check("len0_busy", {63'd0, busy}, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Backpressure in HOLD.
        out_ready = 1'b0;
        reduce(1'b0, 9'd1, 1'b0, 9'd1, 1, {4{16'h3C00}}, {4{8'h05}}, 64'd0, {4{16'h4500}}, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_acc2", out_acc2, {4{16'h4500}});
            check("bp_acc1", out_acc1, 64'd0);
        end
        out_ready = 1'b1;
        wait_idle();
        reduce(vecs[2].mode, vecs[2].len, vecs[2].mode, vecs[2].len, 1,
               vecs[2].act, vecs[2].wgt, vecs[2].e1, vecs[2].e2, 0);
        wait_idle();

        // Reset after 2 of 4 beats aborts with no output.
        send_beat(1'b0, 9'd4, {4{16'h3C00}}, {4{8'h02}});
        send_beat(1'b0, 9'd4, {4{16'h3C00}}, {4{8'h02}});
        @(posedge clk); #1;
        check("partial_busy", {63'd0, busy}, 64'd1);
        check("partial_acc2", out_acc2, {4{16'h4400}});
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd0);
        check("abort_acc1", out_acc1, 64'd0);
        check("abort_acc2", out_acc2, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Mode and length changes after the first beat are ignored.
        reduce(1'b0, 9'd4, 1'b1, 9'd2, 4, {4{16'h3C00}}, {4{8'h02}}, 64'd0, {4{16'h4800}}, 0);
        wait_idle();

        // Length above K_MAX clamps to K_MAX beats.
        reduce(1'b0, 9'd300, 1'b0, 9'd300, K_MAX, {4{16'h3C00}}, {4{8'h01}}, 64'd0, {4{16'h5C00}}, 0);
        wait_idle();

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
